// File: rtl/riscv_pkg.sv
// Shared core types: regfile write-port record and the writeback arbiter state encoding.
package riscv_pkg;

    localparam int RF_ADDR_W = 5;
    localparam int RF_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        PEND,
        STALL
    } wb_arb_state_e;

    typedef struct packed {
        logic                 we;
        logic [RF_ADDR_W-1:0] waddr;
        logic [RF_DATA_W-1:0] wdata;
    } rf_wr_t;

endpackage

// File: rtl/wb_arb_fifo.sv
// Small synchronous FIFO holding long-latency results until a free regfile write slot appears.
module wb_arb_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    // A push into a full FIFO is legal only when the head leaves in the same cycle.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the regfile write port between pipeline writeback and a long-latency unit.
// Optional macro WB_ARB_LU_BYPASS_EN: zero-latency LU write when the port and buffer are idle.
module wb_port_arbiter
    import riscv_pkg::*;
#(
    parameter int ADDR_W    = 5,
    parameter int DATA_W    = 32,
    parameter int BUF_DEPTH = 2,
    parameter int MAX_WAIT  = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         pipe_we_i,
    input  logic [ADDR_W-1:0]            pipe_waddr_i,
    input  logic [DATA_W-1:0]            pipe_wdata_i,
    input  logic                         lu_valid_i,
    input  logic [ADDR_W-1:0]            lu_waddr_i,
    input  logic [DATA_W-1:0]            lu_wdata_i,
    output logic                         lu_ready_o,
    output logic                         pipe_stall_o,
    output logic                         rf_we_o,
    output logic [ADDR_W-1:0]            rf_waddr_o,
    output logic [DATA_W-1:0]            rf_wdata_o,
    output logic [$clog2(BUF_DEPTH):0]   buf_count_o
);

    localparam int CNT_W  = $clog2(BUF_DEPTH) + 1;
    localparam int ENT_W  = ADDR_W + DATA_W;
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    wb_arb_state_e     state;
    wb_arb_state_e     state_next;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_next;

    logic              full;
    logic              empty;
    logic              accept;
    logic              bypass;
    logic              push;
    logic              pop;
    logic [ENT_W-1:0]  head;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;
    logic              win;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_data;

    wb_arb_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (BUF_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata ({lu_waddr_i, lu_wdata_i}),
        .rdata (head),
        .count (buf_count_o),
        .full  (full),
        .empty (empty)
    );

    assign {head_addr, head_data} = head;

    // Ready comes from the pre-pop occupancy, so push+pop at full is never offered.
    assign lu_ready_o = !full;
    assign accept     = lu_valid_i && lu_ready_o;

`ifdef WB_ARB_LU_BYPASS_EN
    assign bypass = accept && empty && (state != STALL) && !pipe_we_i;
`else
    assign bypass = 1'b0;
`endif

    assign push = accept && !bypass;

    always_comb begin
        pop      = 1'b0;
        win      = 1'b0;
        win_addr = '0;
        win_data = '0;
        if (state == STALL) begin
            pop      = 1'b1;
            win      = 1'b1;
            win_addr = head_addr;
            win_data = head_data;
        end else if (pipe_we_i) begin
            win      = 1'b1;
            win_addr = pipe_waddr_i;
            win_data = pipe_wdata_i;
        end else if (!empty) begin
            pop      = 1'b1;
            win      = 1'b1;
            win_addr = head_addr;
            win_data = head_data;
        end else if (bypass) begin
            win      = 1'b1;
            win_addr = lu_waddr_i;
            win_data = lu_wdata_i;
        end
    end

    // x0 is hardwired: the slot is consumed but nothing is written.
    assign rf_we_o      = win && (win_addr != '0);
    assign rf_waddr_o   = win_addr;
    assign rf_wdata_o   = win_data;
    assign pipe_stall_o = (state == STALL);

    always_comb begin
        state_next = state;
        wait_next  = wait_cnt;
        case (state)
            IDLE: begin
                if (push) begin
                    state_next = PEND;
                    wait_next  = '0;
                end
            end
            PEND: begin
                if (pop) begin
                    wait_next = '0;
                    if (buf_count_o == CNT_W'(1) && !push) state_next = IDLE;
                end else if (wait_cnt == WAIT_W'(MAX_WAIT - 1)) begin
                    state_next = STALL;
                    wait_next  = '0;
                end else begin
                    wait_next = wait_cnt + WAIT_W'(1);
                end
            end
            STALL: begin
                wait_next  = '0;
                state_next = (buf_count_o == CNT_W'(1) && !push) ? IDLE : PEND;
            end
            default: begin
                state_next = IDLE;
                wait_next  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            wait_cnt <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_next;
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: expected regfile writes are queued as stimulus is driven.
module tb_wb_port_arbiter;
    import riscv_pkg::*;

    localparam int ADDR_W    = 5;
    localparam int DATA_W    = 32;
    localparam int BUF_DEPTH = 2;
    localparam int MAX_WAIT  = 4;

    logic                       clk = 1'b0;
    logic                       rst;
    logic                       pipe_we_i;
    logic [ADDR_W-1:0]          pipe_waddr_i;
    logic [DATA_W-1:0]          pipe_wdata_i;
    logic                       lu_valid_i;
    logic [ADDR_W-1:0]          lu_waddr_i;
    logic [DATA_W-1:0]          lu_wdata_i;
    logic                       lu_ready_o;
    logic                       pipe_stall_o;
    logic                       rf_we_o;
    logic [ADDR_W-1:0]          rf_waddr_o;
    logic [DATA_W-1:0]          rf_wdata_o;
    logic [$clog2(BUF_DEPTH):0] buf_count_o;

    int     total = 0;
    int     bad   = 0;
    rf_wr_t exp_q[$];
    rf_wr_t mon_e;

    wb_port_arbiter #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .BUF_DEPTH (BUF_DEPTH),
        .MAX_WAIT  (MAX_WAIT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pipe_we_i    (pipe_we_i),
        .pipe_waddr_i (pipe_waddr_i),
        .pipe_wdata_i (pipe_wdata_i),
        .lu_valid_i   (lu_valid_i),
        .lu_waddr_i   (lu_waddr_i),
        .lu_wdata_i   (lu_wdata_i),
        .lu_ready_o   (lu_ready_o),
        .pipe_stall_o (pipe_stall_o),
        .rf_we_o      (rf_we_o),
        .rf_waddr_o   (rf_waddr_o),
        .rf_wdata_o   (rf_wdata_o),
        .buf_count_o  (buf_count_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: sim time limit reached, required finish earlier");
        $fatal(1, "watchdog");
    end

    function automatic rf_wr_t mk(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        rf_wr_t w;
        w.we    = 1'b1;
        w.waddr = a;
        w.wdata = d;
        return w;
    endfunction

    always @(negedge clk) begin
        if (rst === 1'b0 && rf_we_o === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected: got write addr=%0d data=%h, required no write",
                         rf_waddr_o, rf_wdata_o);
            end else begin
                mon_e = exp_q.pop_front();
                if ({rf_waddr_o, rf_wdata_o} !== {mon_e.waddr, mon_e.wdata}) begin
                    bad++;
                    $display("FAIL sb_write: got addr=%0d data=%h, required addr=%0d data=%h",
                             rf_waddr_o, rf_wdata_o, mon_e.waddr, mon_e.wdata);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        pipe_we_i = 1'b0; pipe_waddr_i = '0; pipe_wdata_i = '0;
        lu_valid_i = 1'b0; lu_waddr_i = '0; lu_wdata_i = '0;
        @(negedge clk);
        total++;
        if ({pipe_stall_o, buf_count_o, lu_ready_o} !== {1'b0, 2'd0, 1'b1}) begin
            bad++;
            $display("FAIL reset_ctrl: got stall=%b count=%0d ready=%b, required 0/0/1",
                     pipe_stall_o, buf_count_o, lu_ready_o);
        end
        total++;
        if ({rf_we_o, rf_waddr_o, rf_wdata_o} !== '0) begin
            bad++;
            $display("FAIL reset_rf: got we=%b addr=%0d data=%h, required all 0",
                     rf_we_o, rf_waddr_o, rf_wdata_o);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_lu_latency();
        step();
        lu_valid_i = 1'b1; lu_waddr_i = 5'd5; lu_wdata_i = 32'hDEAD;
        exp_q.push_back(mk(5'd5, 32'hDEAD));
        @(negedge clk);
        total++;
        if (lu_ready_o !== 1'b1) begin
            bad++; $display("FAIL lat_ready: got %b, required 1", lu_ready_o);
        end
        total++;
`ifdef WB_ARB_LU_BYPASS_EN
        if ({rf_we_o, rf_waddr_o} !== {1'b1, 5'd5}) begin
            bad++; $display("FAIL lat_same_cycle: got we=%b addr=%0d, required 1/5", rf_we_o, rf_waddr_o);
        end
`else
        if (rf_we_o !== 1'b0) begin
            bad++; $display("FAIL lat_same_cycle: got we=%b, required 0", rf_we_o);
        end
`endif
        step();
        lu_valid_i = 1'b0;
        @(negedge clk);
        total++;
`ifdef WB_ARB_LU_BYPASS_EN
        if (rf_we_o !== 1'b0) begin
            bad++; $display("FAIL lat_next_cycle: got we=%b, required 0", rf_we_o);
        end
`else
        if ({rf_we_o, rf_waddr_o} !== {1'b1, 5'd5}) begin
            bad++; $display("FAIL lat_next_cycle: got we=%b addr=%0d, required 1/5", rf_we_o, rf_waddr_o);
        end
`endif
        step();
        @(negedge clk);
        total++;
        if (buf_count_o !== 2'd0) begin
            bad++; $display("FAIL lat_count: got %0d, required 0", buf_count_o);
        end
    endtask

    task automatic test_stall();
        step();
        pipe_we_i = 1'b1; pipe_waddr_i = 5'd10; pipe_wdata_i = 32'h1000_000A;
        lu_valid_i = 1'b1; lu_waddr_i = 5'd7; lu_wdata_i = 32'h0000_7777;
        exp_q.push_back(mk(5'd10, 32'h1000_000A));
        @(negedge clk);
        total++;
        if (pipe_stall_o !== 1'b0) begin
            bad++; $display("FAIL stall_c0: got %b, required 0", pipe_stall_o);
        end
        for (int i = 1; i <= 4; i++) begin
            step();
            lu_valid_i = 1'b0;
            pipe_waddr_i = 5'(10 + i);
            pipe_wdata_i = 32'h1000_0000 + 32'(10 + i);
            exp_q.push_back(mk(pipe_waddr_i, pipe_wdata_i));
            @(negedge clk);
            total++;
            if (pipe_stall_o !== 1'b0) begin
                bad++; $display("FAIL stall_denied%0d: got %b, required 0", i, pipe_stall_o);
            end
        end
        step();
        pipe_waddr_i = 5'd15; pipe_wdata_i = 32'h1000_000F;
        exp_q.push_back(mk(5'd7, 32'h0000_7777));
        @(negedge clk);
        total++;
        if ({pipe_stall_o, rf_waddr_o} !== {1'b1, 5'd7}) begin
            bad++; $display("FAIL stall_fifth: got stall=%b addr=%0d, required 1/7", pipe_stall_o, rf_waddr_o);
        end
        step();
        exp_q.push_back(mk(5'd15, 32'h1000_000F));
        @(negedge clk);
        total++;
        if ({pipe_stall_o, rf_waddr_o} !== {1'b0, 5'd15}) begin
            bad++; $display("FAIL stall_resume: got stall=%b addr=%0d, required 0/15", pipe_stall_o, rf_waddr_o);
        end
        step();
        pipe_we_i = 1'b0;
        @(negedge clk);
        total++;
        if (buf_count_o !== 2'd0 || exp_q.size() != 0) begin
            bad++; $display("FAIL stall_drain: got count=%0d pending=%0d, required 0/0", buf_count_o, exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        bit accepted = 1'b0;
        step();
        pipe_we_i = 1'b1; pipe_waddr_i = '0; pipe_wdata_i = '0;
        lu_valid_i = 1'b1; lu_waddr_i = 5'd1; lu_wdata_i = 32'hA1;
        exp_q.push_back(mk(5'd1, 32'hA1));
        @(negedge clk);
        total++;
        if (lu_ready_o !== 1'b1) begin
            bad++; $display("FAIL b2b_ready0: got %b, required 1", lu_ready_o);
        end
        step();
        lu_waddr_i = 5'd2; lu_wdata_i = 32'hA2;
        exp_q.push_back(mk(5'd2, 32'hA2));
        @(negedge clk);
        total++;
        if ({lu_ready_o, buf_count_o} !== {1'b1, 2'd1}) begin
            bad++; $display("FAIL b2b_second: got ready=%b count=%0d, required 1/1", lu_ready_o, buf_count_o);
        end
        step();
        lu_waddr_i = 5'd3; lu_wdata_i = 32'hA3;
        exp_q.push_back(mk(5'd3, 32'hA3));
        @(negedge clk);
        total++;
        if ({lu_ready_o, buf_count_o} !== {1'b0, 2'd2}) begin
            bad++; $display("FAIL b2b_full: got ready=%b count=%0d, required 0/2", lu_ready_o, buf_count_o);
        end
        for (int i = 0; i < 20 && !accepted; i++) begin
            step();
            @(negedge clk);
            if (lu_ready_o === 1'b1) accepted = 1'b1;
            else begin
                total++;
                if (buf_count_o !== 2'd2) begin
                    bad++; $display("FAIL b2b_held: got count=%0d while not ready, required 2", buf_count_o);
                end
            end
        end
        total++;
        if (!accepted) begin
            bad++; $display("FAIL b2b_timeout: got ready=0 for 20 cycles, required a pop");
        end
        step();
        lu_valid_i = 1'b0;
        pipe_we_i = 1'b0;
        for (int i = 0; i < 20 && buf_count_o != 0; i++) step();
        @(negedge clk);
        total++;
        if (buf_count_o !== 2'd0 || exp_q.size() != 0) begin
            bad++; $display("FAIL b2b_drain: got count=%0d pending=%0d, required 0/0", buf_count_o, exp_q.size());
        end
    endtask

    task automatic test_full_pushpop();
        step();
        pipe_we_i = 1'b1; pipe_waddr_i = '0; pipe_wdata_i = '0;
        lu_valid_i = 1'b1; lu_waddr_i = 5'd20; lu_wdata_i = 32'hC020;
        exp_q.push_back(mk(5'd20, 32'hC020));
        step();
        lu_waddr_i = 5'd21; lu_wdata_i = 32'hC021;
        exp_q.push_back(mk(5'd21, 32'hC021));
        step();
        pipe_we_i = 1'b0;
        lu_waddr_i = 5'd22; lu_wdata_i = 32'hC022;
        exp_q.push_back(mk(5'd22, 32'hC022));
        @(negedge clk);
        total++;
        if ({buf_count_o, lu_ready_o, rf_we_o, rf_waddr_o} !== {2'd2, 1'b0, 1'b1, 5'd20}) begin
            bad++; $display("FAIL full_pop: got count=%0d ready=%b we=%b addr=%0d, required 2/0/1/20",
                            buf_count_o, lu_ready_o, rf_we_o, rf_waddr_o);
        end
        step();
        @(negedge clk);
        total++;
        if ({buf_count_o, lu_ready_o, rf_waddr_o} !== {2'd1, 1'b1, 5'd21}) begin
            bad++; $display("FAIL full_pushpop: got count=%0d ready=%b addr=%0d, required 1/1/21",
                            buf_count_o, lu_ready_o, rf_waddr_o);
        end
        step();
        lu_valid_i = 1'b0;
        @(negedge clk);
        total++;
        if ({buf_count_o, rf_waddr_o} !== {2'd1, 5'd22}) begin
            bad++; $display("FAIL full_kept: got count=%0d addr=%0d, required 1/22", buf_count_o, rf_waddr_o);
        end
        step();
        @(negedge clk);
        total++;
        if (buf_count_o !== 2'd0 || exp_q.size() != 0) begin
            bad++; $display("FAIL full_drain: got count=%0d pending=%0d, required 0/0", buf_count_o, exp_q.size());
        end
    endtask

    task automatic test_addr_zero();
        step();
        pipe_we_i = 1'b1; pipe_waddr_i = '0; pipe_wdata_i = 32'hDEADBEEF;
        lu_valid_i = 1'b1; lu_waddr_i = '0; lu_wdata_i = 32'h1234;
        @(negedge clk);
        total++;
        if (rf_we_o !== 1'b0) begin
            bad++; $display("FAIL x0_pipe: got we=%b, required 0", rf_we_o);
        end
        step();
        pipe_we_i = 1'b0; lu_valid_i = 1'b0;
        @(negedge clk);
        total++;
        if ({buf_count_o, rf_we_o} !== {2'd1, 1'b0}) begin
            bad++; $display("FAIL x0_lu_pop: got count=%0d we=%b, required 1/0", buf_count_o, rf_we_o);
        end
        step();
        @(negedge clk);
        total++;
        if (buf_count_o !== 2'd0) begin
            bad++; $display("FAIL x0_consumed: got count=%0d, required 0", buf_count_o);
        end
    endtask

    task automatic test_reset_in_stall();
        bit seen = 1'b0;
        step();
        pipe_we_i = 1'b1; pipe_waddr_i = '0; pipe_wdata_i = '0;
        lu_valid_i = 1'b1; lu_waddr_i = 5'd30; lu_wdata_i = 32'hE030;
        exp_q.push_back(mk(5'd30, 32'hE030));
        step();
        lu_waddr_i = 5'd31; lu_wdata_i = 32'hE031;
        step();
        lu_valid_i = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (pipe_stall_o === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        total++;
        if (!seen || buf_count_o !== 2'd2) begin
            bad++; $display("FAIL rst_stall_setup: got seen=%b count=%0d, required 1/2", seen, buf_count_o);
        end
        #1;
        rst = 1'b1;
        #1;
        total++;
        if ({pipe_stall_o, buf_count_o, lu_ready_o} !== {1'b0, 2'd0, 1'b1}) begin
            bad++; $display("FAIL rst_async: got stall=%b count=%0d ready=%b, required 0/0/1",
                            pipe_stall_o, buf_count_o, lu_ready_o);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        pipe_we_i = 1'b0;
        @(negedge clk);
        total++;
        if (exp_q.size() != 0 || buf_count_o !== 2'd0) begin
            bad++; $display("FAIL rst_discard: got pending=%0d count=%0d, required 0/0", exp_q.size(), buf_count_o);
        end
        exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_lu_latency();
        test_stall();
        test_back_to_back();
        test_full_pushpop();
        test_addr_zero();
        test_reset_in_stall();
        repeat (3) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
